serial_deframer: RTL and testbench
==================================

Name: serial_deframer

Overview:
- Bit-serial frame receiver. Sits directly downstream of the timing-test DFF stage and consumes its registered q output as a serial stream.
- Hunts for a sync pattern, then deserialises the fixed number of data words that follow it.
- Checks the sync pattern again at every frame boundary.
- Delivers words through a small FIFO with a valid/ready handshake, so the cocotb bench can check timing-dependent data integrity.

Parameters:
- WORD_W, 8: data word width in bits.
- SYNC_W, 8: sync pattern width in bits.
- SYNC_PATTERN, 8'hA5: sync value, SYNC_W bits wide.
- FRAME_WORDS, 2: data words per frame, >=1.
- FIFO_DEPTH, 4: output FIFO entries, power of 2, >=2.

Ports:
- clk  in  1  clock; all logic is on the posedge.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data, MSB first; driven by the upstream q.
- bit_en  in  1  qualifies bit_in; a bit is consumed only when this is 1.
- word_data  out  WORD_W  FIFO head word.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accept.
- locked  out  1  high in states DATA and RESYNC.
- overflow  out  1  sticky; a word was dropped.
- sync_err_count  out  8  saturating count of lost-lock events.
- word_count  out  16  words accepted into the FIFO; wraps modulo 2^16.

Behaviour:
- Reset (rst=1 at posedge), all synchronous:
  - state=HUNT.
  - Shift register, fill counter, bit counter and word counter = 0.
  - FIFO empty.
  - All outputs 0; word_data=0 while empty.
  - Reset mid-frame discards all partial and buffered data.
- bit_en=0: shift register, counters and state hold. FIFO pop still operates.
- Shift register sr: sr_next = {sr[SYNC_W-2:0], bit_in} on every consumed bit, in all states.
- HUNT:
  - Fill counter saturates at SYNC_W.
  - When fill counter (including the current bit) >= SYNC_W and sr_next == SYNC_PATTERN: go to DATA, clear bit and word counters.
  - The fill requirement prevents false match on reset contents.
- DATA:
  - Accumulate WORD_W bits MSB first.
  - On the WORD_W-th bit, push the assembled word.
  - After FRAME_WORDS words, go to RESYNC with bit counter 0.
- RESYNC:
  - Collect SYNC_W bits.
  - On the SYNC_W-th bit: sr_next == SYNC_PATTERN -> DATA.
  - Otherwise -> HUNT with the fill counter at SYNC_W, sr keeping those bits, and sync_err_count +1 (saturates at 255).
  - From the next bit on, hunting continues bit-by-bit; no bits are lost.
- locked timing:
  - Rises in the cycle after the posedge that consumes the last sync bit.
  - Falls in the cycle after the posedge that detects a RESYNC mismatch.
- FIFO:
  - First-word-fall-through. A pushed word appears on word_data with word_valid=1 in the cycle after the posedge that consumed its last bit.
  - Pop when word_valid && word_ready.
  - Push into a full FIFO is accepted if a pop occurs the same cycle; otherwise the word is dropped and overflow is set (cleared only by rst).
  - word_count increments only on accepted pushes.
  - Simultaneous push and pop on an empty FIFO is not possible: the pushed word is not yet visible.
- word_data stays stable while word_valid && !word_ready.
- All outputs are registered.

Test Plan:
- Basic frame (word_ready=1, bit_en=1): stream A5 3C C3 A5 11 22 -> words 3C, C3, 11, 22 in order; locked=1 from the cycle after bit 8; word_count=4; sync_err_count=0; overflow=0.
- Hunt with misaligned prefix: bits 1,0,1, then A5 3C C3 -> exactly 3C, C3 delivered; no false lock during the prefix; after reset with a 00 pattern parameterisation, no lock before 8 bits.
- Lost lock: A5 01 02 FF, then 3 more bits 1,0,1 -> locked falls after FF's last bit; sync_err_count=1; only 01, 02 delivered. Then A5 77 88 -> relock; 77, 88 delivered.
- Overflow: word_ready=0; stream A5 01 02 A5 03 04 A5 05 -> FIFO holds 01..04; 05 dropped; overflow=1; word_count=4. Then raise word_ready -> exactly 01, 02, 03, 04 drained.
- Backpressure and gaps: random bit_en duty of 50% and random word_ready -> same word sequence as with gaps removed; word_data stable while stalled; push-on-full with a same-cycle pop accepted, no overflow.
- Reset mid-frame: rst pulsed after 12 bits of A5 3C C3 -> all outputs 0 the next cycle, FIFO empty. Subsequent A5 AA BB yields AA, BB with word_count=2.

Source files
------------

// File: rtl/serial_deframer.sv
// rtl/serial_deframer.sv - bit-serial sync-hunting frame receiver with FWFT output FIFO
//
// Ports:
//   clk, rst        posedge clock, synchronous active-high reset
//   bit_in, bit_en  serial data (MSB first) and its per-cycle qualifier
//   word_data       FIFO head word (0 while empty)
//   word_valid      FIFO not empty
//   word_ready      consumer accept; pop when word_valid && word_ready
//   locked          high while in DATA or RESYNC
//   overflow        sticky, a completed word was dropped on a full FIFO
//   sync_err_count  saturating count of lost-lock events
//   word_count      words accepted into the FIFO, wraps at 2^16

module serial_deframer #(
  parameter int                WORD_W       = 8,
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
  parameter int                FRAME_WORDS  = 2,
  parameter int                FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_en,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              locked,
  output logic              overflow,
  output logic [7:0]        sync_err_count,
  output logic [15:0]       word_count
);

  localparam int MAX_W  = (WORD_W > SYNC_W) ? WORD_W : SYNC_W;
  localparam int CNT_W  = $clog2(MAX_W);
  localparam int FILL_W = $clog2(SYNC_W + 1);
  localparam int WIDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_W - 1);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(FRAME_WORDS - 1);
  localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    RESYNC = 2'd2
  } state_t;

  state_t state, state_n;

  // Only the older SYNC_W-1 bits are stored; the newest bit is always the
  // live bit_in, so {sr, bit_in} is the full sync window.
  logic [SYNC_W-2:0] sr, sr_n;
  logic [SYNC_W-1:0] sr_full;
  logic [FILL_W-1:0] fill, fill_n;
  logic [CNT_W-1:0]  bit_cnt, bit_n;
  logic [WIDX_W-1:0] widx, widx_n;
  logic [WORD_W-2:0] wsr, wsr_n;
  logic [WORD_W-1:0] word_full;
  logic              push;
  logic [7:0]        sync_err_n;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_n, wr_n;
  logic [PTR_W:0]    fifo_count, count_n;
  logic              pop, push_ok;
  logic [WORD_W-1:0] head_n;
  logic [15:0]       word_count_n;
  logic              overflow_n;

  // Framing state machine
  always_comb begin
    state_n    = state;
    sr_n       = sr;
    fill_n     = fill;
    bit_n      = bit_cnt;
    widx_n     = widx;
    wsr_n      = wsr;
    push       = 1'b0;
    sync_err_n = sync_err_count;
    sr_full    = {sr, bit_in};
    word_full  = {wsr, bit_in};

    if (bit_en) begin
      sr_n = sr_full[SYNC_W-2:0];
      case (state)
        HUNT: begin
          if (fill != FILL_FULL) fill_n = fill + 1'b1;
          // fill >= SYNC_W-1 means this bit completes a window of real bits
          if (fill >= FILL_LAST && sr_full == SYNC_PATTERN) begin
            state_n = DATA;
            bit_n   = '0;
            widx_n  = '0;
          end
        end
        DATA: begin
          wsr_n = word_full[WORD_W-2:0];
          if (bit_cnt == WORD_LAST) begin
            push  = 1'b1;
            bit_n = '0;
            if (widx == WIDX_LAST) begin
              state_n = RESYNC;
              widx_n  = '0;
            end else begin
              widx_n = widx + 1'b1;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
        RESYNC: begin
          if (bit_cnt == SYNC_LAST) begin
            bit_n = '0;
            if (sr_full == SYNC_PATTERN) begin
              state_n = DATA;
              widx_n  = '0;
            end else begin
              // Window is already full of real bits, so hunting resumes
              // bit-by-bit from here without discarding anything.
              state_n = HUNT;
              fill_n  = FILL_FULL;
              if (sync_err_count != 8'hFF) sync_err_n = sync_err_count + 1'b1;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // FIFO next-state; the head word is precomputed so word_data is a register
  always_comb begin
    pop     = word_valid & word_ready;
    push_ok = push & ((fifo_count != FIFO_FULL) | pop);
    rd_n    = pop ? rd_ptr + 1'b1 : rd_ptr;
    wr_n    = push_ok ? wr_ptr + 1'b1 : wr_ptr;
    case ({push_ok, pop})
      2'b10:   count_n = fifo_count + 1'b1;
      2'b01:   count_n = fifo_count - 1'b1;
      default: count_n = fifo_count;
    endcase
    // A push landing on the new read slot only happens when that word
    // becomes the sole entry, so it must bypass the storage array.
    if (count_n == '0) begin
      head_n = '0;
    end else if (push_ok && wr_ptr == rd_n) begin
      head_n = word_full;
    end else begin
      head_n = mem[rd_n];
    end
    word_count_n = push_ok ? word_count + 1'b1 : word_count;
    overflow_n   = overflow | (push & ~push_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= word_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= HUNT;
      sr             <= '0;
      fill           <= '0;
      bit_cnt        <= '0;
      widx           <= '0;
      wsr            <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      fifo_count     <= '0;
      word_data      <= '0;
      word_valid     <= 1'b0;
      locked         <= 1'b0;
      overflow       <= 1'b0;
      sync_err_count <= '0;
      word_count     <= '0;
    end else begin
      state          <= state_n;
      sr             <= sr_n;
      fill           <= fill_n;
      bit_cnt        <= bit_n;
      widx           <= widx_n;
      wsr            <= wsr_n;
      rd_ptr         <= rd_n;
      wr_ptr         <= wr_n;
      fifo_count     <= count_n;
      word_data      <= head_n;
      word_valid     <= (count_n != '0);
      locked         <= (state_n != HUNT);
      overflow       <= overflow_n;
      sync_err_count <= sync_err_n;
      word_count     <= word_count_n;
    end
  end

endmodule

// File: tb/tb_serial_deframer.sv
// tb/tb_serial_deframer.sv - randomized and directed bench for serial_deframer

module tb_serial_deframer;

  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_en = 1'b0;
  logic        word_ready = 1'b0;
  logic [7:0]  word_data;
  logic        word_valid;
  logic        locked;
  logic        overflow;
  logic [7:0]  sync_err_count;
  logic [15:0] word_count;

  logic [7:0]  z_word_data;
  logic        z_word_valid;
  logic        z_locked;
  logic        z_overflow;
  logic [7:0]  z_sync_err_count;
  logic [15:0] z_word_count;

  serial_deframer #(
    .WORD_W(8), .SYNC_W(8), .SYNC_PATTERN(8'hA5), .FRAME_WORDS(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .locked(locked), .overflow(overflow), .sync_err_count(sync_err_count),
    .word_count(word_count)
  );

  // All-zero sync pattern: the reset contents must not count as a match.
  serial_deframer #(
    .WORD_W(8), .SYNC_W(8), .SYNC_PATTERN(8'h00), .FRAME_WORDS(2), .FIFO_DEPTH(4)
  ) dut_zero (
    .clk(clk), .rst(rst), .bit_in(1'b0), .bit_en(bit_en),
    .word_data(z_word_data), .word_valid(z_word_valid), .word_ready(1'b1),
    .locked(z_locked), .overflow(z_overflow), .sync_err_count(z_sync_err_count),
    .word_count(z_word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame parser over the consumed bit stream plus a bounded queue
  int         m_mode;   // 0 hunting, 1 data, 2 checking sync
  int         m_nbits, m_win, m_cnt, m_cur, m_words, m_err, m_wc;
  bit         m_ovf;
  logic [7:0] m_q[$];
  logic [7:0] got_q[$];

  bit gaps = 0;
  bit rand_ready = 0;
  bit ready_lvl = 1;

  task automatic model_reset();
    m_mode = 0; m_nbits = 0; m_win = 0; m_cnt = 0; m_cur = 0;
    m_words = 0; m_err = 0; m_wc = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic model_step(input logic en, input logic b, input logic rdy);
    bit pop, push;
    int pw, sz;
    pop  = rdy && (m_q.size() > 0);
    push = 0;
    pw   = 0;
    if (en) begin
      m_nbits++;
      m_win = ((m_win << 1) | int'(b)) & 255;
      if (m_mode == 0) begin
        if (m_nbits >= 8 && m_win == int'(SYNC)) begin
          m_mode = 1; m_cnt = 0; m_words = 0; m_cur = 0;
        end
      end else if (m_mode == 1) begin
        m_cur = ((m_cur << 1) | int'(b)) & 255;
        m_cnt++;
        if (m_cnt == 8) begin
          push = 1; pw = m_cur; m_cnt = 0; m_cur = 0; m_words++;
          if (m_words == 2) m_mode = 2;
        end
      end else begin
        m_cnt++;
        if (m_cnt == 8) begin
          m_cnt = 0;
          if (m_win == int'(SYNC)) begin
            m_mode = 1; m_words = 0;
          end else begin
            m_mode = 0;
            if (m_err < 255) m_err++;
          end
        end
      end
    end
    sz = m_q.size();
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (sz < 4 || pop) begin
        m_q.push_back(pw[7:0]);
        m_wc = (m_wc + 1) & 16'hFFFF;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  function automatic logic rdy_now();
    if (rand_ready) return logic'($urandom_range(0, 1));
    return ready_lvl;
  endfunction

  task automatic step(input logic en, input logic b, input logic rdy);
    logic       stalled;
    logic [7:0] held;
    bit_en     = en;
    bit_in     = b;
    word_ready = rdy;
    stalled    = word_valid && !rdy;
    held       = word_data;
    if (word_valid && rdy) got_q.push_back(word_data);
    model_step(en, b, rdy);
    @(posedge clk);
    #1;
    check_val("locked", {31'd0, locked}, {31'd0, m_mode != 0});
    check_val("word_valid", {31'd0, word_valid}, {31'd0, m_q.size() > 0});
    check_val("word_data", {24'd0, word_data}, (m_q.size() > 0) ? {24'd0, m_q[0]} : 32'd0);
    check_val("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check_val("word_count", {16'd0, word_count}, m_wc);
    check_val("sync_err_count", {24'd0, sync_err_count}, m_err);
    if (stalled && word_valid) check_val("stall_stable", {24'd0, word_data}, {24'd0, held});
  endtask

  task automatic do_reset();
    rst = 1'b1; bit_en = 1'b0; word_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    got_q.delete();
    check_val("rst_word_data", {24'd0, word_data}, 0);
    check_val("rst_word_valid", {31'd0, word_valid}, 0);
    check_val("rst_locked", {31'd0, locked}, 0);
    check_val("rst_overflow", {31'd0, overflow}, 0);
    check_val("rst_sync_err", {24'd0, sync_err_count}, 0);
    check_val("rst_word_count", {16'd0, word_count}, 0);
  endtask

  task automatic send_bit(input logic b);
    if (gaps) begin
      for (int g = 0; g < 4; g++) begin
        if ($urandom_range(0, 1) == 0) break;
        step(1'b0, logic'($urandom_range(0, 1)), rdy_now());
      end
    end
    step(1'b1, b, rdy_now());
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy_now());
  endtask

  task automatic check_words(input string tag, input logic [7:0] exp[$]);
    check_val({tag, "_n"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check_val(tag, {24'd0, got_q[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] v;
    int         nz;

    // Basic frame
    do_reset();
    gaps = 0; rand_ready = 0; ready_lvl = 1;
    v = SYNC;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      if (i == 1) check_val("lock_before_8", {31'd0, locked}, 0);
      if (i == 0) check_val("lock_after_8", {31'd0, locked}, 1);
    end
    send_byte(8'h3C); send_byte(8'hC3);
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
    idle(4);
    exp_q = '{8'h3C, 8'hC3, 8'h11, 8'h22};
    check_words("basic_words", exp_q);
    check_val("basic_wc", {16'd0, word_count}, 4);
    check_val("basic_err", {24'd0, sync_err_count}, 0);
    check_val("basic_ovf", {31'd0, overflow}, 0);

    // Misaligned prefix; all-zero pattern instance must wait for 8 real bits
    do_reset();
    nz = 0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    nz = 3;
    check_val("prefix_no_lock", {31'd0, locked}, 0);
    v = SYNC;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      nz++;
      if (nz == 7) check_val("zero_pat_no_lock_7", {31'd0, z_locked}, 0);
      if (nz == 8) check_val("zero_pat_lock_8", {31'd0, z_locked}, 1);
    end
    send_byte(8'h3C); send_byte(8'hC3);
    idle(4);
    exp_q = '{8'h3C, 8'hC3};
    check_words("prefix_words", exp_q);

    // Lost lock and relock
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    v = 8'hFF;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      if (i == 1) check_val("lost_still_locked", {31'd0, locked}, 1);
      if (i == 0) check_val("lost_unlocked", {31'd0, locked}, 0);
    end
    check_val("lost_err", {24'd0, sync_err_count}, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check_val("lost_hunting", {31'd0, locked}, 0);
    send_byte(8'hA5);
    check_val("relock", {31'd0, locked}, 1);
    send_byte(8'h77); send_byte(8'h88);
    idle(4);
    exp_q = '{8'h01, 8'h02, 8'h77, 8'h88};
    check_words("relock_words", exp_q);

    // Overflow with the consumer stalled
    do_reset();
    ready_lvl = 0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hA5); send_byte(8'h05);
    check_val("ovf_flag", {31'd0, overflow}, 1);
    check_val("ovf_wc", {16'd0, word_count}, 4);
    ready_lvl = 1;
    idle(8);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_words("ovf_drain", exp_q);
    check_val("ovf_empty", {31'd0, word_valid}, 0);

    // Push into a full FIFO with a same-cycle pop
    do_reset();
    ready_lvl = 0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hA5);
    v = 8'h05;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    ready_lvl = 1;
    send_bit(v[0]);
    check_val("full_pop_ovf", {31'd0, overflow}, 0);
    check_val("full_pop_wc", {16'd0, word_count}, 5);
    idle(8);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_words("full_pop_words", exp_q);

    // Reset mid-frame
    do_reset();
    send_byte(8'hA5);
    v = 8'h3C;
    for (int i = 7; i >= 4; i--) send_bit(v[i]);
    do_reset();
    send_byte(8'hA5); send_byte(8'hAA); send_byte(8'hBB);
    idle(4);
    exp_q = '{8'hAA, 8'hBB};
    check_words("midrst_words", exp_q);
    check_val("midrst_wc", {16'd0, word_count}, 2);

    // Random gaps and backpressure over clean frames
    do_reset();
    gaps = 1; rand_ready = 1;
    exp_q.delete();
    for (int f = 0; f < 10; f++) begin
      send_byte(SYNC);
      for (int w = 0; w < 2; w++) begin
        v = 8'($urandom_range(0, 255));
        exp_q.push_back(v);
        send_byte(v);
      end
    end
    gaps = 0; rand_ready = 0; ready_lvl = 1;
    idle(8);
    check_words("rand_words", exp_q);
    check_val("rand_ovf", {31'd0, overflow}, 0);
    check_val("rand_wc", {16'd0, word_count}, 20);

    // Random byte soup with sync bytes sprinkled in; model checks every cycle
    do_reset();
    gaps = 1; rand_ready = 1;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) != 0) send_byte(SYNC);
      else send_byte(8'($urandom_range(0, 255)));
    end
    gaps = 0; rand_ready = 0;
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
